bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 84 ++++++++
 tb/tb_bin2bcd_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BIN_W_DEF  = 27;
  localparam int unsigned DIGITS_DEF = 8;
  localparam int unsigned MAX_VAL    = 99_999_999;

  // Bit-counter width able to hold the value bits (0..bits).
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(BIN_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3 before the left shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, saturating at all 9s.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CW    = cnt_width(BIN_W);

  state_t             state;
  logic [BIN_W-1:0]   sh;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj;
  logic [CW-1:0]      cnt;
  logic               ovf_pend;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .digit (acc[4*i +: 4]),
      .fixed (acc_adj[4*i +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh       <= bin;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 64'(bin) > 64'(MAX_VAL);
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A bit leaving the top digit can only happen for an out-of-range value; keep it sticky.
          acc      <= {acc_adj[BCD_W-2:0], sh[BIN_W-1]};
          sh       <= {sh[BIN_W-2:0], 1'b0};
          ovf_pend <= ovf_pend | acc_adj[BCD_W-1];
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(BIN_W - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_out <= ovf_pend ? {DIGITS{4'h9}} : acc;
          ovf     <= ovf_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random values against a decimal model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal digit extraction with saturation.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = '0;
    if (v > 99_999_999) return 32'h9999_9999;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return v > 99_999_999;
  endfunction

  // One conversion from IDLE; noisy mode toggles start and scrambles bin while busy.
  task automatic run_conv(input logic [26:0] v, input bit noisy, input string tag);
    int  n;
    int  busy_cnt;
    int  extra;
    bit  got;
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    n = 0; busy_cnt = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      start = (noisy && n < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) bin = 27'($urandom);
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, n, 29);
    check_eq({tag, "_bcd"}, bcd_out, ref_bcd(32'(v)));
    check_eq({tag, "_ovf"}, ovf, ref_ovf(32'(v)));
    check_eq({tag, "_busy_cycles"}, busy_cnt, 28);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_eq({tag, "_quiet_after"}, extra, 0);
  endtask

  initial begin
    int dones;
    int seen;
    logic [26:0] hist[$];
    logic [26:0] v;

    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_bcd", bcd_out, 0);
    check_eq("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(27'd12_345_678, 1'b0, "d12345678");
    run_conv(27'd0,          1'b0, "dzero");
    run_conv(27'd99_999_999, 1'b0, "dmax");
    run_conv(27'd100_000_000, 1'b0, "dovf_low");
    run_conv(27'h7FF_FFFF,   1'b0, "dovf_top");
    run_conv(27'd12_345_678, 1'b1, "dnoisy");

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; bin = 27'd5;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_prio_busy", busy, 0);
    check_eq("rst_prio_bcd", bcd_out, 0);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq("rst_prio_no_done", seen, 0);

    // Abort a conversion of 42 with reset at its tenth edge.
    run_conv(27'd7, 1'b0, "pre_abort");
    bin = 27'd42; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_bcd", bcd_out, 0);
    check_eq("abort_ovf", ovf, 0);
    rst = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq("abort_no_done", seen, 0);
    run_conv(27'd42, 1'b0, "after_abort");
    check_eq("after_abort_hex", bcd_out, 32'h0000_0042);

    // start held high, bin changing every cycle: accepts every 29 edges.
    dones = 0;
    for (int c = 0; c < 116; c++) begin
      bin = 27'($urandom);
      hist.push_back(bin);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dones++;
        check_eq("b2b_spacing", (c >= 28 && (c - 28) % 29 == 0), 1);
        if (c >= 28) begin
          check_eq("b2b_bcd", bcd_out, ref_bcd(32'(hist[c-28])));
          check_eq("b2b_ovf", ovf, ref_ovf(32'(hist[c-28])));
        end
      end
    end
    start = 1'b0;
    check_eq("b2b_count", dones, 4);
    repeat (32) @(negedge clk);
    check_eq("b2b_idle", busy, 0);

    for (int i = 0; i < 1000; i++) begin
      v = (i % 2 == 0) ? 27'($urandom_range(0, 99_999_999)) : 27'($urandom);
      run_conv(v, 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
